// File: rtl/rv32_halt_ctrl.sv
// Halt controller: detects EBREAK/ECALL accepted in ID, freezes fetch, drains EX/MEM/WB, then raises sticky halt.
// A watchdog forces halt on timeout. Optional HALT_CYCLE_COUNT_EN adds a cycle counter output for CPI reporting.
module rv32_halt_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned TIMEOUT      = 100,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [31:0]      i_id_instr,
    input  logic             i_stall,
    input  logic             i_flush,
    output logic             o_fetch_freeze,
    output logic             o_halt,
    output logic [1:0]       o_halt_cause
`ifdef HALT_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] o_cycle_count
`endif
);

    localparam int unsigned      DRAIN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [31:0]      EBREAK_W = 32'h0010_0073;
    localparam logic [31:0]      ECALL_W  = 32'h0000_0073;
    localparam bit               WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_EBREAK = 2'b01;
    localparam logic [1:0] CAUSE_ECALL  = 2'b10;
    localparam logic [1:0] CAUSE_WDOG   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t             r_state;
    logic               r_freeze;
    logic               r_halt;
    logic [1:0]         r_cause;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0]   r_wd_cnt;

    logic       w_is_ebreak;
    logic       w_is_ecall;
    logic       w_accept;
    logic [1:0] w_cause;
    logic       w_wd_fire;

    // Exact-match decode; a flushed or stalled halt instruction is not accepted.
    assign w_is_ebreak = (i_id_instr == EBREAK_W);
    assign w_is_ecall  = (i_id_instr == ECALL_W);
    assign w_accept    = i_id_valid & (w_is_ebreak | w_is_ecall) & ~i_stall & ~i_flush;
    assign w_cause     = w_is_ebreak ? CAUSE_EBREAK : CAUSE_ECALL;
    assign w_wd_fire   = WD_EN && (r_wd_cnt == WD_LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_freeze    <= 1'b0;
            r_halt      <= 1'b0;
            r_cause     <= CAUSE_NONE;
            r_drain_cnt <= '0;
            r_wd_cnt    <= '0;
        end else begin
            // Watchdog runs until halted and saturates rather than wrapping.
            if (r_state != ST_HALTED && r_wd_cnt != '1) begin
                r_wd_cnt <= r_wd_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        assert (DRAIN_CYCLES != 0)
                            else $error("rv32_halt_ctrl: DRAIN_CYCLES must be at least 1");
                        r_state     <= ST_DRAIN;
                        r_freeze    <= 1'b1;
                        r_cause     <= w_cause;
                        r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
                    end else if (w_wd_fire) begin
                        r_state  <= ST_HALTED;
                        r_freeze <= 1'b1;
                        r_halt   <= 1'b1;
                        r_cause  <= CAUSE_WDOG;
                    end
                end

                // Older instructions retire; ID-side inputs no longer matter.
                ST_DRAIN: begin
                    r_freeze <= 1'b1;
                    if (r_drain_cnt == '0) begin
                        r_state <= ST_HALTED;
                        r_halt  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end

                ST_HALTED: begin
                    r_freeze <= 1'b1;
                    r_halt   <= 1'b1;
                end

                default: begin
                    r_state  <= ST_RUN;
                    r_freeze <= 1'b0;
                    r_halt   <= 1'b0;
                    r_cause  <= CAUSE_NONE;
                end
            endcase
        end
    end

    assign o_fetch_freeze = r_freeze;
    assign o_halt         = r_halt;
    assign o_halt_cause   = r_cause;

`ifdef HALT_CYCLE_COUNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;

    // Counts cycles since reset release; the count stops on the edge that enters HALTED.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cycle_cnt <= '0;
        end else if (r_state != ST_HALTED && r_cycle_cnt != '1) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign o_cycle_count = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_rv32_halt_ctrl.sv
// Directed bench for rv32_halt_ctrl: two instances (3-cycle drain with 20-cycle watchdog,
// 1-cycle drain with watchdog off) driven in lockstep, expectations queued and checked each edge.
module tb_rv32_halt_ctrl;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] CSRRW  = 32'h0000_1073;
    localparam logic [31:0] EBRD1  = 32'h0010_00F3;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        stall;
    logic        flush;

    logic        f_a, h_a, f_b, h_b;
    logic [1:0]  c_a, c_b;
`ifdef HALT_CYCLE_COUNT_EN
    logic [31:0] n_a, n_b;
`endif

    always #5 clk = ~clk;

    rv32_halt_ctrl #(.DRAIN_CYCLES(3), .TIMEOUT(20), .CNT_W(32)) u_dut_a (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_valid     (id_valid),
        .i_id_instr     (id_instr),
        .i_stall        (stall),
        .i_flush        (flush),
        .o_fetch_freeze (f_a),
        .o_halt         (h_a),
        .o_halt_cause   (c_a)
`ifdef HALT_CYCLE_COUNT_EN
        ,
        .o_cycle_count  (n_a)
`endif
    );

    rv32_halt_ctrl #(.DRAIN_CYCLES(1), .TIMEOUT(0), .CNT_W(32)) u_dut_b (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_valid     (id_valid),
        .i_id_instr     (id_instr),
        .i_stall        (stall),
        .i_flush        (flush),
        .o_fetch_freeze (f_b),
        .o_halt         (h_b),
        .o_halt_cause   (c_b)
`ifdef HALT_CYCLE_COUNT_EN
        ,
        .o_cycle_count  (n_b)
`endif
    );

    typedef struct {
        string       tag;
        logic        f_a;
        logic        h_a;
        logic [1:0]  c_a;
        logic        f_b;
        logic        h_b;
        logic [1:0]  c_b;
        int unsigned n_a;
        int unsigned n_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the state expected after the next edge, then check it.
    task automatic step(input string tag, input logic r, input logic v, input logic [31:0] ins,
                        input logic s, input logic fl,
                        input logic ef_a, input logic eh_a, input logic [1:0] ec_a,
                        input logic ef_b, input logic eh_b, input logic [1:0] ec_b,
                        input int unsigned en_a, input int unsigned en_b);
        exp_t e;
        rst      = r;
        id_valid = v;
        id_instr = ins;
        stall    = s;
        flush    = fl;
        e.tag = tag;
        e.f_a = ef_a; e.h_a = eh_a; e.c_a = ec_a;
        e.f_b = ef_b; e.h_b = eh_b; e.c_b = ec_b;
        e.n_a = en_a; e.n_b = en_b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, "_freeze_a"}, 32'(f_a), 32'(e.f_a));
        chk({e.tag, "_halt_a"},   32'(h_a), 32'(e.h_a));
        chk({e.tag, "_cause_a"},  32'(c_a), 32'(e.c_a));
        chk({e.tag, "_freeze_b"}, 32'(f_b), 32'(e.f_b));
        chk({e.tag, "_halt_b"},   32'(h_b), 32'(e.h_b));
        chk({e.tag, "_cause_b"},  32'(c_b), 32'(e.c_b));
`ifdef HALT_CYCLE_COUNT_EN
        chk({e.tag, "_count_a"},  n_a, e.n_a);
        chk({e.tag, "_count_b"},  n_b, e.n_b);
`endif
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_instr = NOP; stall = 1'b0; flush = 1'b0;

        // EBREAK accepted on edge 10: freeze next, halt 3 edges later (1 for instance b).
        step("s1_rst", 1, 0, NOP, 0, 0, 0,0,2'b00, 0,0,2'b00, 0, 0);
        for (int i = 1; i <= 9; i++)
            step($sformatf("s1_idle%0d", i), 0, 1, NOP, 0, 0, 0,0,2'b00, 0,0,2'b00, i, i);
        step("s1_acc",   0, 1, EBREAK, 0, 0, 1,0,2'b01, 1,0,2'b01, 10, 10);
        step("s1_d1",    0, 1, NOP,    0, 0, 1,0,2'b01, 1,1,2'b01, 11, 11);
        step("s1_d2",    0, 1, NOP,    0, 0, 1,0,2'b01, 1,1,2'b01, 12, 11);
        step("s1_halt",  0, 1, NOP,    0, 0, 1,1,2'b01, 1,1,2'b01, 13, 11);
        for (int i = 14; i <= 23; i++)
            step($sformatf("s1_hold%0d", i), 0, 1, ECALL, 0, 0, 1,1,2'b01, 1,1,2'b01, 13, 11);

        // ECALL held by stall for two cycles, accepted on the third; flush during drain is ignored.
        step("s2_rst",   1, 0, NOP,    0, 0, 0,0,2'b00, 0,0,2'b00, 0, 0);
        step("s2_st1",   0, 1, ECALL,  1, 0, 0,0,2'b00, 0,0,2'b00, 1, 1);
        step("s2_st2",   0, 1, ECALL,  1, 0, 0,0,2'b00, 0,0,2'b00, 2, 2);
        step("s2_acc",   0, 1, ECALL,  0, 0, 1,0,2'b10, 1,0,2'b10, 3, 3);
        step("s2_d1",    0, 1, EBREAK, 0, 1, 1,0,2'b10, 1,1,2'b10, 4, 4);
        step("s2_d2",    0, 0, NOP,    0, 0, 1,0,2'b10, 1,1,2'b10, 5, 4);
        step("s2_halt",  0, 0, NOP,    0, 0, 1,1,2'b10, 1,1,2'b10, 6, 4);
        step("s2_hold",  0, 0, NOP,    0, 0, 1,1,2'b10, 1,1,2'b10, 6, 4);

        // Non-accepted patterns, then watchdog on a at edge 20; b has no watchdog.
        step("s3_rst",   1, 0, NOP,    0, 0, 0,0,2'b00, 0,0,2'b00, 0, 0);
        step("s3_flush", 0, 1, EBREAK, 0, 1, 0,0,2'b00, 0,0,2'b00, 1, 1);
        step("s3_stfl",  0, 1, EBREAK, 1, 1, 0,0,2'b00, 0,0,2'b00, 2, 2);
        step("s3_mret",  0, 1, MRET,   0, 0, 0,0,2'b00, 0,0,2'b00, 3, 3);
        step("s3_inval", 0, 0, EBREAK, 0, 0, 0,0,2'b00, 0,0,2'b00, 4, 4);
        step("s3_csr",   0, 1, CSRRW,  0, 0, 0,0,2'b00, 0,0,2'b00, 5, 5);
        step("s3_ebrd",  0, 1, EBRD1,  0, 0, 0,0,2'b00, 0,0,2'b00, 6, 6);
        for (int i = 7; i <= 19; i++)
            step($sformatf("s4_idle%0d", i), 0, 1, NOP, 0, 0, 0,0,2'b00, 0,0,2'b00, i, i);
        step("s4_wdog",  0, 1, NOP,    0, 0, 1,1,2'b11, 0,0,2'b00, 20, 20);
        step("s4_h21",   0, 1, NOP,    0, 0, 1,1,2'b11, 0,0,2'b00, 20, 21);
        step("s4_h22",   0, 1, NOP,    0, 0, 1,1,2'b11, 0,0,2'b00, 20, 22);
        step("s4_bacc",  0, 1, EBREAK, 0, 0, 1,1,2'b11, 1,0,2'b01, 20, 23);
        step("s4_bhalt", 0, 1, NOP,    0, 0, 1,1,2'b11, 1,1,2'b01, 20, 24);
        step("s4_hold",  0, 1, NOP,    0, 0, 1,1,2'b11, 1,1,2'b01, 20, 24);

        // Accept on the same edge the watchdog would fire: the instruction wins.
        step("s5_rst",   1, 0, NOP,    0, 0, 0,0,2'b00, 0,0,2'b00, 0, 0);
        for (int i = 1; i <= 19; i++)
            step($sformatf("s5_idle%0d", i), 0, 1, NOP, 0, 0, 0,0,2'b00, 0,0,2'b00, i, i);
        step("s5_acc",   0, 1, EBREAK, 0, 0, 1,0,2'b01, 1,0,2'b01, 20, 20);
        step("s5_d1",    0, 1, NOP,    0, 0, 1,0,2'b01, 1,1,2'b01, 21, 21);
        step("s5_d2",    0, 1, NOP,    0, 0, 1,0,2'b01, 1,1,2'b01, 22, 21);
        step("s5_halt",  0, 1, NOP,    0, 0, 1,1,2'b01, 1,1,2'b01, 23, 21);
        step("s5_hold",  0, 1, NOP,    0, 0, 1,1,2'b01, 1,1,2'b01, 23, 21);

        // Reset mid-drain and in HALTED, each with a halt instruction present, then halt again.
        step("s6_rst",   1, 0, NOP,    0, 0, 0,0,2'b00, 0,0,2'b00, 0, 0);
        step("s6_i1",    0, 1, NOP,    0, 0, 0,0,2'b00, 0,0,2'b00, 1, 1);
        step("s6_i2",    0, 1, NOP,    0, 0, 0,0,2'b00, 0,0,2'b00, 2, 2);
        step("s6_acc",   0, 1, EBREAK, 0, 0, 1,0,2'b01, 1,0,2'b01, 3, 3);
        step("s6_rstd",  1, 1, ECALL,  0, 0, 0,0,2'b00, 0,0,2'b00, 0, 0);
        step("s6_acc2",  0, 1, EBREAK, 0, 0, 1,0,2'b01, 1,0,2'b01, 1, 1);
        step("s6_d1",    0, 1, NOP,    0, 0, 1,0,2'b01, 1,1,2'b01, 2, 2);
        step("s6_d2",    0, 1, NOP,    0, 0, 1,0,2'b01, 1,1,2'b01, 3, 2);
        step("s6_halt",  0, 1, NOP,    0, 0, 1,1,2'b01, 1,1,2'b01, 4, 2);
        step("s6_rsth",  1, 1, ECALL,  0, 0, 0,0,2'b00, 0,0,2'b00, 0, 0);
        step("s6_acc3",  0, 1, ECALL,  0, 0, 1,0,2'b10, 1,0,2'b10, 1, 1);
        step("s6_e1",    0, 1, NOP,    0, 0, 1,0,2'b10, 1,1,2'b10, 2, 2);
        step("s6_e2",    0, 1, NOP,    0, 0, 1,0,2'b10, 1,1,2'b10, 3, 2);
        step("s6_halt2", 0, 1, NOP,    0, 0, 1,1,2'b10, 1,1,2'b10, 4, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
